// File: rtl/distort_pkg.sv
// Shared types and helpers for the random-offset distortion scheduler.
// State encoding, LFSR taps/seed, next-state and offset-direction helpers.
package distort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // 16-bit Galois LFSR, right shift
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // 1 = add the offset, 0 = subtract it
    function automatic logic offset_dir(input logic [15:0] l);
        return ((l[7:0] % 8'd10) <= 8'd5);
    endfunction

endpackage

// File: rtl/distort_sched_if.sv
// Sample stream handshake bundle: input side (source -> block) and output side (block -> sink).
// slave is the scheduler's view, master is the source/sink view.
interface distort_sched_if #(parameter int DATA_W = 8);

    logic [DATA_W-1:0] in_sample;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_sample;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_sample, in_valid, out_ready,
        output in_ready, out_sample, out_valid
    );

    modport master (
        output in_sample, in_valid, out_ready,
        input  in_ready, out_sample, out_valid
    );

endinterface

// File: rtl/distort_lfsr.sv
// Holds the single offset LFSR; steps once per asserted adv, otherwise holds.
module distort_lfsr
    import distort_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= SEED;
        else if (adv)
            r_lfsr <= lfsr_next(r_lfsr);
    end

    assign value = r_lfsr;

endmodule

// File: rtl/distort_sched.sv
// Random-offset distortion scheduler: one sample in flight, IDLE -> CALC -> OUT.
// Define DISTORT_SAT_EN to clamp over/underflow and count clamps in clip_cnt; otherwise results wrap.
module distort_sched
    import distort_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter int          CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [2:0]          cfg_depth,
    distort_sched_if.slave      bus,
    output logic                busy,
    output logic [CNT_W-1:0]    clip_cnt
);

    state_t            r_state;
    logic [DATA_W-1:0] r_sample;
    logic              r_en;
    logic [2:0]        r_depth;
    logic [15:0]       r_l;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;

    logic [15:0]       w_lfsr;
    logic              w_adv;
    logic              w_accept;
    logic [2:0]        w_j;
    logic              w_add;
    logic [DATA_W-1:0] w_result;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    // Bypass samples leave the sequence untouched
    assign w_adv    = w_accept && cfg_en;

    distort_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (w_adv),
        .value (w_lfsr)
    );

    assign w_j   = (r_l[10:8] < r_depth) ? r_l[10:8] : r_depth;
    assign w_add = offset_dir(r_l);

`ifdef DISTORT_SAT_EN
    logic [DATA_W:0]   w_ext;
    logic [DATA_W:0]   w_off;
    logic [DATA_W:0]   w_sum;
    logic              w_clip;
    logic [CNT_W-1:0]  r_clip_cnt;

    assign w_ext = {1'b0, r_sample};
    assign w_off = {{(DATA_W-2){1'b0}}, w_j};
    // Top bit is the carry on add and the borrow on subtract
    assign w_sum = w_add ? (w_ext + w_off) : (w_ext - w_off);

    always_comb begin
        w_result = r_sample;
        w_clip   = 1'b0;
        if (r_en) begin
            if (w_sum[DATA_W]) begin
                w_clip   = 1'b1;
                w_result = w_add ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            end else begin
                w_result = w_sum[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_clip_cnt <= '0;
        else if ((r_state == CALC) && w_clip && (r_clip_cnt != {CNT_W{1'b1}}))
            r_clip_cnt <= r_clip_cnt + 1'b1;
    end

    assign clip_cnt = r_clip_cnt;
`else
    logic [DATA_W-1:0] w_off;
    logic [DATA_W-1:0] w_sum;

    assign w_off = {{(DATA_W-3){1'b0}}, w_j};
    assign w_sum = w_add ? (r_sample + w_off) : (r_sample - w_off);

    always_comb begin
        w_result = r_sample;
        if (r_en)
            w_result = w_sum;
    end

    assign clip_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sample    <= '0;
            r_en        <= 1'b0;
            r_depth     <= '0;
            r_l         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sample <= bus.in_sample;
                        r_en     <= cfg_en;
                        r_depth  <= cfg_depth;
                        r_l      <= w_lfsr;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_out       <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_sample = r_out;
    assign bus.out_valid  = r_out_valid;
    assign busy           = (r_state != IDLE);

endmodule
